// File: rtl/sram_2mx8_wb_ctrl_if.sv
// Wishbone classic 32-bit bus bundle for the 2Mx8 SRAM controller.
// The master drives the request; the slave returns data, ack and err.
interface sram_2mx8_wb_ctrl_if;
  logic [31:0] i_wb_adr;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [31:0] o_wb_dat;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/sram_2mx8_wb_ctrl.sv
// Wishbone slave splitting each 32-bit access into byte cycles on a 4-chip 2Mx8 async SRAM bank.
// Optional macro SRAM_WB_ADDR_ERR_EN: error-ack requests with nonzero i_wb_adr[31:23].
module sram_2mx8_wb_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int WB_DWIDTH   = 32
) (
  input  logic                  i_brd_clk,
  input  logic                  i_reset_n,
  sram_2mx8_wb_ctrl_if.slave    wb,
  output logic [3:0]            o_sram_cs_n,
  output logic                  o_sram_read_n,
  output logic                  o_sram_write_n,
  output logic [20:0]           o_sram_addr,
  inout  wire  [7:0]            io_sram_data,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

  if (WB_DWIDTH != 32 || WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_param
    $error("sram_2mx8_wb_ctrl: unsupported parameter value");
  end

  state_t      state_q, state_d;
  logic [18:0] adr_q, adr_d;
  logic [1:0]  chip_q, chip_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        addr_err;
  logic [3:0]  rem_next;
  logic        busy;
  logic        drv_en;
  logic        unused_adr;

`ifdef SRAM_WB_ADDR_ERR_EN
  assign addr_err = |wb.i_wb_adr[31:23];
`else
  assign addr_err = 1'b0;
`endif
  // Word-offset bits are implied by the lane; upper bits alias unless checked.
  assign unused_adr = ^{wb.i_wb_adr[31:23], wb.i_wb_adr[1:0]};

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    low_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) low_lane = 2'(i);
    end
  endfunction

  always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      chip_q  <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      chip_q  <= chip_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    chip_d   = chip_q;
    we_d     = we_q;
    dat_d    = dat_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rem_next = rem_q & ~(4'b0001 << lane_q);
    case (state_q)
      IDLE: begin
        if (wb.i_wb_cyc && wb.i_wb_stb) begin
          adr_d   = wb.i_wb_adr[20:2];
          chip_d  = wb.i_wb_adr[22:21];
          we_d    = wb.i_wb_we;
          dat_d   = wb.i_wb_dat;
          rem_d   = wb.i_wb_sel;
          lane_d  = low_lane(wb.i_wb_sel);
          rdata_d = '0;
          err_d   = addr_err;
          state_d = (addr_err || wb.i_wb_sel == 4'b0000) ? ACK : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = 4'(WAIT_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          // Read data is captured on the edge that closes the strobe window.
          if (!we_q) rdata_d[lane_q*8 +: 8] = io_sram_data;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        rem_d = rem_next;
        if (rem_next != 4'b0000) begin
          lane_d  = low_lane(rem_next);
          state_d = SETUP;
        end else begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign drv_en         = busy && we_q;
  assign o_sram_cs_n    = busy ? ~(4'b0001 << chip_q) : 4'hF;
  assign o_sram_read_n  = !((state_q == STROBE) && !we_q);
  assign o_sram_write_n = !((state_q == STROBE) && we_q);
  assign o_sram_addr    = busy ? {adr_q, lane_q} : 21'd0;
  assign io_sram_data   = drv_en ? dat_q[lane_q*8 +: 8] : 8'bz;

  assign wb.o_wb_ack = (state_q == ACK) && !err_q;
  assign wb.o_wb_dat = ((state_q == ACK) && !err_q) ? rdata_q : 32'd0;
`ifdef SRAM_WB_ADDR_ERR_EN
  assign wb.o_wb_err = (state_q == ACK) && err_q;
`else
  assign wb.o_wb_err = 1'b0;
`endif
  assign o_dbg_state = state_q;

endmodule
